// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, read/write encodings and FSM state type for the data cache
package dcache_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INDEX_W = 6;
  localparam int DEF_OFFSET_W = 2;
  localparam int TAG_W = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W - 2;
  localparam int WORDS = 1 << DEF_OFFSET_W;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: processor-side and memory-side strobe/ready buses of the data cache
interface dcache_if import dcache_pkg::*; #(parameter int AW = DEF_ADDR_W);
  logic Pstrobe;
  logic PRW;
  logic [AW-1:0] Paddr;
  logic [3:0] Pwen;
  logic [31:0] Pdata_in;
  logic [31:0] Pdata_out;
  logic PReady;
  logic Mstrobe;
  logic MRW;
  logic [AW-1:0] Maddr;
  logic [3:0] Mwen;
  logic [31:0] Mdata_out;
  logic [31:0] Mdata_in;
  logic MReady;
  modport slave (
    input Pstrobe, PRW, Paddr, Pwen, Pdata_in, Mdata_in, MReady,
    output Pdata_out, PReady, Mstrobe, MRW, Maddr, Mwen, Mdata_out
  );
  modport master (
    output Pstrobe, PRW, Paddr, Pwen, Pdata_in, Mdata_in, MReady,
    input Pdata_out, PReady, Mstrobe, MRW, Maddr, Mwen, Mdata_out
  );
endinterface

// File: rtl/dcache_store.sv
// dcache_store: valid/tag/data arrays with combinational read and refill, byte-masked and validate writes
module dcache_store import dcache_pkg::*; #(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int TW = TAG_W
) (
  input logic clk,
  input logic rst,
  input logic [INDEX_W-1:0] i_index,
  input logic [OFFSET_W-1:0] i_offset,
  output logic o_valid,
  output logic [TW-1:0] o_tag,
  output logic [31:0] o_word,
  input logic i_fill_we,
  input logic [31:0] i_fill_data,
  input logic [3:0] i_hit_wen,
  input logic [31:0] i_hit_data,
  input logic i_validate,
  input logic [TW-1:0] i_tag
);
  logic [(1<<INDEX_W)-1:0] r_valid;
  logic [TW-1:0] r_tag [1<<INDEX_W];
  logic [31:0] r_data [1<<INDEX_W][1<<OFFSET_W];
  assign o_valid = r_valid[i_index];
  assign o_tag = r_tag[i_index];
  assign o_word = r_data[i_index][i_offset];
  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else if (i_validate) r_valid[i_index] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (i_validate) r_tag[i_index] <= i_tag;
    if (i_fill_we) r_data[i_index][i_offset] <= i_fill_data;
    for (int b = 0; b < 4; b++)
      if (i_hit_wen[b]) r_data[i_index][i_offset][8*b +: 8] <= i_hit_data[8*b +: 8];
  end
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through no-write-allocate data cache answering the M-stage port
module dcache_responder import dcache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input logic clk,
  input logic rst,
  dcache_if.slave bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int TW = ADDR_W - INDEX_W - OFFSET_W - 2;
  state_t r_state;
  logic [OFFSET_W-1:0] r_cnt;
  logic r_mstrobe;
  logic r_mrw;
  logic [ADDR_W-1:0] r_maddr;
  logic [3:0] r_mwen;
  logic [31:0] r_mdata;
  logic [TW-1:0] w_tag;
  logic [TW-1:0] w_stag;
  logic [INDEX_W-1:0] w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic [OFFSET_W-1:0] w_next;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0] w_word;
  logic w_valid;
  logic w_hit;
  logic w_rd_hit;
  logic w_last;
  logic w_fill_we;
  assign w_offset = bus.Paddr[OFFSET_W+1:2];
  assign w_index = bus.Paddr[OFFSET_W+2 +: INDEX_W];
  assign w_tag = bus.Paddr[ADDR_W-1 -: TW];
  assign w_waddr = bus.Paddr & ~ADDR_W'(3);
  assign w_next = r_cnt + OFFSET_W'(1);
  assign w_last = r_cnt == OFFSET_W'((1 << OFFSET_W) - 1);
  assign w_hit = w_valid && w_stag == w_tag;
  assign w_rd_hit = r_state == IDLE && bus.Pstrobe && bus.PRW == RW_READ && w_hit;
  assign w_fill_we = r_state == REFILL && bus.MReady;
  assign bus.Pdata_out = w_rd_hit ? w_word : '0;
  assign bus.PReady = r_state == IDLE ? (!bus.Pstrobe || w_rd_hit) : (r_state == WRITE && bus.MReady);
  assign bus.Mstrobe = r_mstrobe;
  assign bus.MRW = r_mrw;
  assign bus.Maddr = r_maddr;
  assign bus.Mwen = r_mwen;
  assign bus.Mdata_out = r_mdata;
  dcache_store #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TW(TW)) u_store (
    .clk(clk),
    .rst(rst),
    .i_index(w_index),
    .i_offset(r_state == REFILL ? r_cnt : w_offset),
    .o_valid(w_valid),
    .o_tag(w_stag),
    .o_word(w_word),
    .i_fill_we(w_fill_we),
    .i_fill_data(bus.Mdata_in),
    .i_hit_wen(r_state == WRITE && bus.MReady && w_hit ? bus.Pwen : 4'b0000),
    .i_hit_data(bus.Pdata_in),
    .i_validate(w_fill_we && w_last),
    .i_tag(w_tag)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      r_mstrobe <= 1'b0;
      r_mrw <= RW_READ;
      r_maddr <= '0;
      r_mwen <= '0;
      r_mdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.Pstrobe && bus.PRW == RW_READ && w_hit) hit_cnt <= hit_cnt + 32'd1;
          else if (bus.Pstrobe && bus.PRW == RW_READ) begin
            miss_cnt <= miss_cnt + 32'd1;
            r_state <= REFILL;
            r_cnt <= '0;
            r_mstrobe <= 1'b1;
            r_mrw <= RW_READ;
            r_maddr <= {w_tag, w_index, OFFSET_W'(0), 2'b00};
          end else if (bus.Pstrobe) begin
            r_state <= WRITE;
            r_mstrobe <= 1'b1;
            r_mrw <= RW_WRITE;
            r_maddr <= w_waddr;
            r_mwen <= bus.Pwen;
            r_mdata <= bus.Pdata_in;
          end
        end
        REFILL: begin
          if (bus.MReady) begin
            r_cnt <= w_next;
            r_maddr <= {w_tag, w_index, w_next, 2'b00};
            if (w_last) begin
              r_state <= IDLE;
              r_mstrobe <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (bus.MReady) begin
            r_state <= IDLE;
            r_mstrobe <= 1'b0;
            r_mrw <= RW_READ;
            r_mwen <= '0;
            r_mdata <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed self-checking bench for the data cache responder
module tb_dcache_responder;
  import dcache_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  int total = 0;
  int bad = 0;
  logic [31:0] fill0 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  dcache_if bus();
  dcache_responder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  initial begin
    bus.Pstrobe = 1'b0;
    bus.PRW = RW_READ;
    bus.Paddr = '0;
    bus.Pwen = '0;
    bus.Pdata_in = '0;
    bus.MReady = 1'b0;
    bus.Mdata_in = '0;
    tick();
    tick();
    rst = 1'b0;
    mid();
    chk("rst_pready", bus.PReady, 1);
    chk("rst_mstrobe", bus.Mstrobe, 0);
    chk("rst_mrw", bus.MRW, 1);
    chk("rst_maddr", bus.Maddr, 0);
    chk("rst_mwen", bus.Mwen, 0);
    chk("rst_mdata", bus.Mdata_out, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    tick();
    bus.Pstrobe = 1'b1;
    bus.Paddr = 32'h104;
    mid();
    chk("cold_pready", bus.PReady, 0);
    chk("cold_dout", bus.Pdata_out, 0);
    tick();
    bus.MReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Mdata_in = fill0[i];
      mid();
      chk("fill_maddr", bus.Maddr, 32'h100 + 4 * i);
      chk("fill_mstrobe", bus.Mstrobe, 1);
      chk("fill_mrw", bus.MRW, 1);
      chk("fill_pready", bus.PReady, 0);
      chk("fill_miss", miss_cnt, 1);
      tick();
    end
    bus.MReady = 1'b0;
    mid();
    chk("fill_done_pready", bus.PReady, 1);
    chk("fill_done_dout", bus.Pdata_out, 32'h22);
    chk("fill_done_mstrobe", bus.Mstrobe, 0);
    tick();
    bus.Paddr = 32'h10C;
    mid();
    chk("hit_pready", bus.PReady, 1);
    chk("hit_dout", bus.Pdata_out, 32'h44);
    chk("hit_mstrobe", bus.Mstrobe, 0);
    chk("hit_cnt1", hit_cnt, 1);
    chk("miss_cnt1", miss_cnt, 1);
    tick();
    bus.Pstrobe = 1'b0;
    mid();
    chk("hit_cnt2", hit_cnt, 2);
    chk("idle_pready", bus.PReady, 1);
    chk("idle_dout", bus.Pdata_out, 0);
    tick();
    bus.Pstrobe = 1'b1;
    bus.PRW = RW_WRITE;
    bus.Paddr = 32'h108;
    bus.Pwen = 4'b0001;
    bus.Pdata_in = 32'h0000_00AB;
    mid();
    chk("st_req_pready", bus.PReady, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("st_mstrobe", bus.Mstrobe, 1);
      chk("st_mrw", bus.MRW, 0);
      chk("st_mwen", bus.Mwen, 4'b0001);
      chk("st_maddr", bus.Maddr, 32'h108);
      chk("st_mdata", bus.Mdata_out, 32'hAB);
      chk("st_wait_pready", bus.PReady, 0);
      tick();
    end
    bus.MReady = 1'b1;
    mid();
    chk("st_done_pready", bus.PReady, 1);
    tick();
    bus.MReady = 1'b0;
    bus.PRW = RW_READ;
    mid();
    chk("st_rd_pready", bus.PReady, 1);
    chk("st_rd_dout", bus.Pdata_out, 32'h0000_00AB);
    chk("st_rd_mstrobe", bus.Mstrobe, 0);
    chk("st_rd_mwen", bus.Mwen, 0);
    tick();
    bus.PRW = RW_WRITE;
    bus.Paddr = 32'h2000;
    bus.Pwen = 4'b1111;
    bus.Pdata_in = 32'hDEAD_BEEF;
    mid();
    chk("unc_req_pready", bus.PReady, 0);
    tick();
    bus.MReady = 1'b1;
    mid();
    chk("unc_maddr", bus.Maddr, 32'h2000);
    chk("unc_mdata", bus.Mdata_out, 32'hDEAD_BEEF);
    chk("unc_mwen", bus.Mwen, 4'b1111);
    chk("unc_pready", bus.PReady, 1);
    chk("hit_cnt3", hit_cnt, 3);
    tick();
    bus.MReady = 1'b0;
    bus.PRW = RW_READ;
    mid();
    chk("unc_rd_pready", bus.PReady, 0);
    chk("unc_rd_dout", bus.Pdata_out, 0);
    tick();
    bus.MReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Mdata_in = 32'h50 + i;
      mid();
      chk("unc_fill_maddr", bus.Maddr, 32'h2000 + 4 * i);
      chk("miss_cnt2", miss_cnt, 2);
      tick();
    end
    bus.MReady = 1'b0;
    mid();
    chk("unc_hit_pready", bus.PReady, 1);
    chk("unc_hit_dout", bus.Pdata_out, 32'h50);
    tick();
    bus.PRW = RW_WRITE;
    bus.Paddr = 32'h104;
    bus.Pwen = 4'b0000;
    bus.Pdata_in = 32'hFFFF_FFFF;
    mid();
    chk("z_req_pready", bus.PReady, 0);
    tick();
    bus.MReady = 1'b1;
    mid();
    chk("z_mstrobe", bus.Mstrobe, 1);
    chk("z_mwen", bus.Mwen, 0);
    chk("z_pready", bus.PReady, 1);
    tick();
    bus.MReady = 1'b0;
    bus.PRW = RW_READ;
    mid();
    chk("z_rd_pready", bus.PReady, 1);
    chk("z_rd_dout", bus.Pdata_out, 32'h22);
    tick();
    bus.Paddr = 32'h3000;
    mid();
    chk("rr_req_pready", bus.PReady, 0);
    tick();
    bus.MReady = 1'b1;
    bus.Mdata_in = 32'h99;
    mid();
    chk("rr_w0_maddr", bus.Maddr, 32'h3000);
    tick();
    rst = 1'b1;
    mid();
    chk("rr_w1_maddr", bus.Maddr, 32'h3004);
    tick();
    rst = 1'b0;
    bus.MReady = 1'b0;
    bus.Paddr = 32'h104;
    mid();
    chk("rr_mstrobe", bus.Mstrobe, 0);
    chk("rr_hit", hit_cnt, 0);
    chk("rr_miss", miss_cnt, 0);
    chk("rr_pready", bus.PReady, 0);
    chk("rr_dout", bus.Pdata_out, 0);
    tick();
    mid();
    chk("rr_miss_again", miss_cnt, 1);
    chk("rr_refill_mstrobe", bus.Mstrobe, 1);
    chk("rr_refill_maddr", bus.Maddr, 32'h100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
